// File: rtl/alu_req_ctrl_if.sv
// ----------------------------------------------------------------------------
// alu_req_ctrl_if
// Command / response handshake bundle for alu_req_ctrl.
//   cmd_*  : valid/ready command channel (source -> controller)
//   rsp_*  : valid/ready response channel (controller -> consumer)
// Modports:
//   master : command source / response consumer side
//   slave  : controller side
// ----------------------------------------------------------------------------
interface alu_req_ctrl_if #(
    parameter int TAG_W = 4
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [35:0]      cmd_a;
    logic [35:0]      cmd_b;
    logic [TAG_W-1:0] cmd_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [35:0]      rsp_data;
    logic             rsp_error;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_error, rsp_tag
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_error, rsp_tag
    );
endinterface

// File: rtl/alu_req_ctrl.sv
// ----------------------------------------------------------------------------
// alu_req_ctrl
// Requester-side controller for a registered 36-bit ALU. Takes one command at
// a time on the cmd channel, drives registered op/A/B to the ALU, waits out the
// ALU latency, captures Y/error and returns them with the command tag on the
// rsp channel.
//
// Parameters:
//   ALU_LAT  register stages between ALU operand inputs and Y/error (>=1)
//   TAG_W    width of the opaque command tag
// Ports:
//   clk_i        clock, all logic on posedge
//   reset_i      synchronous, active-high reset
//   bus          alu_req_ctrl_if.slave (cmd_* in, rsp_* out)
//   alu_op_o     ALU op (0 add, 1 sub, 2 mult, 3 div), registered
//   alu_a_o      ALU operand A, registered
//   alu_b_o      ALU operand B, registered
//   alu_y_i      ALU result
//   alu_error_i  ALU error flag
//   busy_o       controller not idle
// Optional (macro ALU_REQ_STATS_EN):
//   stat_cmd_cnt_o  saturating count of response handshakes
//   stat_err_cnt_o  saturating count of handshakes carrying rsp_error=1
// ----------------------------------------------------------------------------
module alu_req_ctrl #(
    parameter int ALU_LAT = 1,
    parameter int TAG_W   = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    alu_req_ctrl_if.slave bus,
    output logic [1:0]  alu_op_o,
    output logic [35:0] alu_a_o,
    output logic [35:0] alu_b_o,
    input  logic [35:0] alu_y_i,
    input  logic        alu_error_i,
    output logic        busy_o
`ifdef ALU_REQ_STATS_EN
    ,
    output logic [15:0] stat_cmd_cnt_o,
    output logic [15:0] stat_err_cnt_o
`endif
);

    localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [35:0]      a_q, a_d;
    logic [35:0]      b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [35:0]      rsp_data_q, rsp_data_d;
    logic             rsp_error_q, rsp_error_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

    logic cmd_ready;
    logic accept;
    logic rsp_hs;

    // Ready in RESP only when the pending response is leaving this cycle,
    // which lets a new command overlap the response handshake.
    assign cmd_ready = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready);
    assign accept    = bus.cmd_valid && cmd_ready;
    assign rsp_hs    = rsp_valid_q && bus.rsp_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        tag_d       = tag_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        rsp_tag_d   = rsp_tag_q;

        case (state_q)
            IDLE: begin
                rsp_valid_d = 1'b0;
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_data_d  = alu_y_i;
                    rsp_error_d = alu_error_i;
                    rsp_tag_d   = tag_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                // Unused encoding: fall back to a clean idle.
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        // Accept overrides the RESP->IDLE transition above.
        if (accept) begin
            op_d    = bus.cmd_op;
            a_d     = bus.cmd_a;
            b_d     = bus.cmd_b;
            tag_d   = bus.cmd_tag;
            cnt_d   = CNT_W'(ALU_LAT);
            state_d = WAIT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            tag_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
            rsp_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
            rsp_tag_q   <= rsp_tag_d;
        end
    end

`ifdef ALU_REQ_STATS_EN
    logic [15:0] stat_cmd_q, stat_cmd_d;
    logic [15:0] stat_err_q, stat_err_d;

    always_comb begin
        stat_cmd_d = stat_cmd_q;
        stat_err_d = stat_err_q;
        if (rsp_hs && (stat_cmd_q != 16'hFFFF)) begin
            stat_cmd_d = stat_cmd_q + 16'd1;
        end
        if (rsp_hs && rsp_error_q && (stat_err_q != 16'hFFFF)) begin
            stat_err_d = stat_err_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stat_cmd_q <= '0;
            stat_err_q <= '0;
        end else begin
            stat_cmd_q <= stat_cmd_d;
            stat_err_q <= stat_err_d;
        end
    end

    assign stat_cmd_cnt_o = stat_cmd_q;
    assign stat_err_cnt_o = stat_err_q;
`else
    logic unused_hs;
    assign unused_hs = rsp_hs;
`endif

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_error = rsp_error_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign alu_op_o      = op_q;
    assign alu_a_o       = a_q;
    assign alu_b_o       = b_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_req_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alu_req_ctrl
// Self-checking bench for alu_req_ctrl: directed scenarios plus a randomized
// run checked against a transaction-level model (one outstanding command,
// response due a fixed number of cycles after acceptance). A behavioural
// registered ALU sits on the alu_* side.
// ----------------------------------------------------------------------------
module tb_alu_req_ctrl;
    localparam int ALU_LAT = 1;
    localparam int TAG_W   = 4;

    logic        clk;
    logic        reset;
    logic [1:0]  alu_op;
    logic [35:0] alu_a, alu_b, alu_y;
    logic        alu_error;
    logic        busy;
`ifdef ALU_REQ_STATS_EN
    logic [15:0] stat_cmd_cnt, stat_err_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    alu_req_ctrl_if #(.TAG_W(TAG_W)) bus ();

    alu_req_ctrl #(.ALU_LAT(ALU_LAT), .TAG_W(TAG_W)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .bus        (bus),
        .alu_op_o   (alu_op),
        .alu_a_o    (alu_a),
        .alu_b_o    (alu_b),
        .alu_y_i    (alu_y),
        .alu_error_i(alu_error),
        .busy_o     (busy)
`ifdef ALU_REQ_STATS_EN
        ,
        .stat_cmd_cnt_o(stat_cmd_cnt),
        .stat_err_cnt_o(stat_err_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {error, y} of the ALU for one operation
    function automatic logic [36:0] alu_f(input logic [1:0] op, input logic [35:0] a, input logic [35:0] b);
        logic signed [71:0] p;
        logic signed [35:0] q;
        case (op)
            2'd0: alu_f = {1'b0, a + b};
            2'd1: alu_f = {1'b0, a - b};
            2'd2: begin
                p = $signed(a) * $signed(b);
                alu_f = {1'b0, p[35:0]};
            end
            default: begin
                if (b == 36'd0) alu_f = {1'b1, 36'd0};
                else begin
                    q = $signed(a) / $signed(b);
                    alu_f = {1'b0, q};
                end
            end
        endcase
    endfunction

    // Behavioural registered ALU with ALU_LAT stages
    logic [35:0] ypipe [ALU_LAT];
    logic        epipe [ALU_LAT];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ALU_LAT; i++) begin
                ypipe[i] <= '0;
                epipe[i] <= 1'b0;
            end
        end else begin
            ypipe[0] <= alu_f(alu_op, alu_a, alu_b)[35:0];
            epipe[0] <= alu_f(alu_op, alu_a, alu_b)[36];
            for (int i = 1; i < ALU_LAT; i++) begin
                ypipe[i] <= ypipe[i-1];
                epipe[i] <= epipe[i-1];
            end
        end
    end
    assign alu_y     = ypipe[ALU_LAT-1];
    assign alu_error = epipe[ALU_LAT-1];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Present one command (controller assumed idle), then wait for rsp_valid.
    // lat = cycles between the accept-edge cycle and rsp_valid visible.
    task automatic run_cmd(input logic [1:0] op, input logic [35:0] a, input logic [35:0] b,
                           input logic [TAG_W-1:0] tag, output int lat);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_tag   = tag;
        tick();
        bus.cmd_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %0h want 0", bus.rsp_valid); end
        n_chk++; if ({bus.rsp_data, bus.rsp_error, bus.rsp_tag} !== '0) begin n_fail++; $display("FAIL reset_rsp_fields got %0h want 0", {bus.rsp_data, bus.rsp_error, bus.rsp_tag}); end
        n_chk++; if ({alu_op, alu_a, alu_b} !== '0) begin n_fail++; $display("FAIL reset_alu got %0h want 0", {alu_op, alu_a, alu_b}); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0h want 0", busy); end
        n_chk++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %0h want 1", bus.cmd_ready); end
`ifdef ALU_REQ_STATS_EN
        n_chk++; if ({stat_cmd_cnt, stat_err_cnt} !== 32'd0) begin n_fail++; $display("FAIL reset_stats got %0h want 0", {stat_cmd_cnt, stat_err_cnt}); end
`endif
    endtask

    task automatic test_add();
        int lat;
        bus.rsp_ready = 1'b1;
        run_cmd(2'd0, 36'd5, 36'd7, 4'd3, lat);
        n_chk++; if (lat != ALU_LAT + 1) begin n_fail++; $display("FAIL add_latency got %0d want %0d", lat, ALU_LAT + 1); end
        n_chk++; if (bus.rsp_data !== 36'd12) begin n_fail++; $display("FAIL add_data got %0h want c", bus.rsp_data); end
        n_chk++; if (bus.rsp_error !== 1'b0) begin n_fail++; $display("FAIL add_error got %0h want 0", bus.rsp_error); end
        n_chk++; if (bus.rsp_tag !== 4'd3) begin n_fail++; $display("FAIL add_tag got %0h want 3", bus.rsp_tag); end
        n_chk++; if (alu_a !== 36'd5 || alu_b !== 36'd7) begin n_fail++; $display("FAIL add_operands_held got %0h/%0h want 5/7", alu_a, alu_b); end
        tick();
        n_chk++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL add_drain got valid %0h busy %0h want 0 0", bus.rsp_valid, busy); end
    endtask

    task automatic test_sub_mult();
        int lat;
        bus.rsp_ready = 1'b1;
        run_cmd(2'd1, 36'd3, 36'd5, 4'd1, lat);
        n_chk++; if (bus.rsp_data !== 36'hF_FFFF_FFFE) begin n_fail++; $display("FAIL sub_data got %0h want ffffffffe", bus.rsp_data); end
        n_chk++; if (bus.rsp_error !== 1'b0) begin n_fail++; $display("FAIL sub_error got %0h want 0", bus.rsp_error); end
        tick();
        run_cmd(2'd2, 36'hF_FFFF_FFFC, 36'd6, 4'd2, lat);
        n_chk++; if (bus.rsp_data !== 36'hF_FFFF_FFE8) begin n_fail++; $display("FAIL mult_data got %0h want fffffffe8", bus.rsp_data); end
        n_chk++; if (bus.rsp_tag !== 4'd2) begin n_fail++; $display("FAIL mult_tag got %0h want 2", bus.rsp_tag); end
        tick();
    endtask

    task automatic test_div();
        int lat;
        bus.rsp_ready = 1'b1;
        run_cmd(2'd3, 36'd10, 36'd0, 4'd7, lat);
        n_chk++; if (bus.rsp_data !== 36'd0 || bus.rsp_error !== 1'b1) begin n_fail++; $display("FAIL div0 got data %0h err %0h want 0 1", bus.rsp_data, bus.rsp_error); end
        tick();
        run_cmd(2'd3, 36'd10, 36'd3, 4'd8, lat);
        n_chk++; if (bus.rsp_data !== 36'd3 || bus.rsp_error !== 1'b0) begin n_fail++; $display("FAIL div got data %0h err %0h want 3 0", bus.rsp_data, bus.rsp_error); end
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        bus.rsp_ready = 1'b0;
        run_cmd(2'd0, 36'd1, 36'd2, 4'd5, lat);
        n_chk++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid got %0h want 1", bus.rsp_valid); end
        // A new command waits while the response is held off.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd1;
        bus.cmd_a     = 36'd9;
        bus.cmd_b     = 36'd4;
        bus.cmd_tag   = 4'd6;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_data !== 36'd3 ||
                bus.rsp_tag !== 4'd5 || alu_a !== 36'd1) bad++;
            tick();
        end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
        bus.rsp_ready = 1'b1;
        #1;
        n_chk++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_on_hs got %0h want 1", bus.cmd_ready); end
        tick();
        bus.cmd_valid = 1'b0;
        n_chk++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b1 || alu_a !== 36'd9) begin n_fail++; $display("FAIL bp_overlap got valid %0h busy %0h a %0h want 0 1 9", bus.rsp_valid, busy, alu_a); end
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        n_chk++; if (lat != ALU_LAT + 1) begin n_fail++; $display("FAIL bp_second_latency got %0d want %0d", lat, ALU_LAT + 1); end
        n_chk++; if (bus.rsp_data !== 36'd5 || bus.rsp_tag !== 4'd6) begin n_fail++; $display("FAIL bp_second_rsp got %0h/%0h want 5/6", bus.rsp_data, bus.rsp_tag); end
        tick();
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle got %0h want 0", busy); end
    endtask

    task automatic test_reset_in_wait();
        int seen;
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd0;
        bus.cmd_a     = 36'd7;
        bus.cmd_b     = 36'd8;
        bus.cmd_tag   = 4'd9;
        tick();
        bus.cmd_valid = 1'b0;
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rw_busy_before got %0h want 1", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_chk++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rw_idle got busy %0h valid %0h want 0 0", busy, bus.rsp_valid); end
        n_chk++; if ({bus.rsp_data, bus.rsp_tag, alu_op, alu_a, alu_b} !== '0) begin n_fail++; $display("FAIL rw_outputs got %0h want 0", {bus.rsp_data, bus.rsp_tag, alu_op, alu_a, alu_b}); end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.rsp_valid) seen++;
            tick();
        end
        n_chk++; if (seen != 0) begin n_fail++; $display("FAIL rw_no_response got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_random();
        bit               pend;
        int               due;
        logic [35:0]      m_data;
        logic             m_err;
        logic [TAG_W-1:0] m_tag;
        bit               e_rv, e_rdy, acc;
        logic [36:0]      r;
        int               t;
        do_reset();
        pend = 0;
        due  = 0;
        m_data = '0;
        m_err  = 1'b0;
        m_tag  = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!bus.cmd_valid && ($urandom_range(0, 9) < 6)) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 0) begin
                    t = int'($urandom_range(0, 200)) - 100;
                    bus.cmd_a = 36'(t);
                end else begin
                    bus.cmd_a = {4'($urandom), 32'($urandom)};
                end
                if ($urandom_range(0, 3) == 0) bus.cmd_b = 36'd0;
                else begin
                    t = int'($urandom_range(1, 50)) - 25;
                    bus.cmd_b = ($urandom_range(0, 1) == 0) ? 36'(t) : {4'($urandom), 32'($urandom)};
                end
                bus.cmd_tag = TAG_W'($urandom);
            end
            bus.rsp_ready = ($urandom_range(0, 9) < 6);
            #1;
            e_rv  = pend && (cyc >= due);
            e_rdy = !pend || (e_rv && bus.rsp_ready);
            n_chk++; if (bus.rsp_valid !== e_rv) begin n_fail++; $display("FAIL rnd_rsp_valid cyc %0d got %0h want %0h", cyc, bus.rsp_valid, e_rv); end
            n_chk++; if (bus.cmd_ready !== e_rdy) begin n_fail++; $display("FAIL rnd_cmd_ready cyc %0d got %0h want %0h", cyc, bus.cmd_ready, e_rdy); end
            n_chk++; if (busy !== pend) begin n_fail++; $display("FAIL rnd_busy cyc %0d got %0h want %0h", cyc, busy, pend); end
            if (e_rv) begin
                n_chk++; if ({bus.rsp_error, bus.rsp_data, bus.rsp_tag} !== {m_err, m_data, m_tag}) begin n_fail++; $display("FAIL rnd_rsp cyc %0d got %0h/%0h/%0h want %0h/%0h/%0h", cyc, bus.rsp_error, bus.rsp_data, bus.rsp_tag, m_err, m_data, m_tag); end
            end
            acc = bus.cmd_valid && e_rdy;
            if (e_rv && bus.rsp_ready) pend = 0;
            if (acc) begin
                r      = alu_f(bus.cmd_op, bus.cmd_a, bus.cmd_b);
                pend   = 1;
                due    = cyc + ALU_LAT + 2;
                m_data = r[35:0];
                m_err  = r[36];
                m_tag  = bus.cmd_tag;
            end
            tick();
            if (acc) bus.cmd_valid = 1'b0;
        end
        bus.cmd_valid = 1'b0;
    endtask

`ifdef ALU_REQ_STATS_EN
    task automatic test_stats();
        int lat;
        do_reset();
        bus.rsp_ready = 1'b1;
        run_cmd(2'd0, 36'd1, 36'd1, 4'd1, lat); tick();
        run_cmd(2'd3, 36'd4, 36'd0, 4'd2, lat); tick();
        run_cmd(2'd1, 36'd9, 36'd2, 4'd3, lat); tick();
        n_chk++; if (stat_cmd_cnt !== 16'd3) begin n_fail++; $display("FAIL stat_cmd got %0d want 3", stat_cmd_cnt); end
        n_chk++; if (stat_err_cnt !== 16'd1) begin n_fail++; $display("FAIL stat_err got %0d want 1", stat_err_cnt); end
        force dut.stat_cmd_q = 16'hFFFF;
        tick();
        release dut.stat_cmd_q;
        run_cmd(2'd0, 36'd2, 36'd2, 4'd4, lat); tick();
        n_chk++; if (stat_cmd_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL stat_cmd_sat got %0h want ffff", stat_cmd_cnt); end
    endtask
`endif

    initial begin
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_tag   = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_sub_mult();
        test_div();
        test_backpressure();
        test_reset_in_wait();
        test_random();
`ifdef ALU_REQ_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
